sync_delay_ctrl: RTL and testbench

Measures the pixel latency of a video processing chain and applies that latency to sideband signals (hsync, vsync, de, or any N-bit group) routed around the chain, keeping them cycle-aligned with the processed pixels. It is the runtime-configurable counterpart to fixed-depth delay chains. It sits beside any HDMI pipeline stage whose latency is unknown or changes with configuration. It has a measurement state machine and a programmable ring-buffer delay.

---
 rtl/sync_delay_ctrl_pkg.sv | 17 +
 rtl/sync_delay_ctrl_if.sv | 31 +++
 rtl/sync_delay_ctrl_var_delay_line.sv | 38 +++
 rtl/sync_delay_ctrl.sv | 104 ++++++++++
 tb/tb_sync_delay_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/sync_delay_ctrl_pkg.sv
// rtl/sync_delay_ctrl_pkg.sv - shared state encoding and width helper for the sync delay controller
package sync_delay_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_MEASURE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_ERROR   = 3'd4
    } state_e;

    // Delay/pointer width for a ring of the given power-of-two depth.
    function automatic int calc_aw(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_delay_ctrl_if.sv
// rtl/sync_delay_ctrl_if.sv - sideband, marker and status signals of the sync delay controller
interface sync_delay_ctrl_if
    import sync_delay_ctrl_pkg::*;
#(
    parameter int N         = 3,
    parameter int MAX_DELAY = 64
);
    localparam int AW = calc_aw(MAX_DELAY);

    logic          ce;
    logic          start;
    logic          ref_in;
    logic          ref_out;
    logic [N-1:0]  in;
    logic [N-1:0]  out;
    logic [AW-1:0] delay;
    logic          busy;
    logic          locked;
    logic          error;

    modport master (
        output ce, start, ref_in, ref_out, in,
        input  out, delay, busy, locked, error
    );

    modport slave (
        input  ce, start, ref_in, ref_out, in,
        output out, delay, busy, locked, error
    );

endinterface

// File: rtl/sync_delay_ctrl_var_delay_line.sv
// rtl/sync_delay_ctrl_var_delay_line.sv - programmable ring-buffer delay with zero-delay bypass
module var_delay_line
    import sync_delay_ctrl_pkg::*;
#(
    parameter int  N         = 3,
    parameter int  MAX_DELAY = 64,
    localparam int AW        = calc_aw(MAX_DELAY)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic [AW-1:0] delay,
    input  logic [N-1:0]  in,
    output logic [N-1:0]  out
);

    logic [N-1:0]  ring [MAX_DELAY];
    logic [AW-1:0] wp;
    logic [AW-1:0] rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            for (int i = 0; i < MAX_DELAY; i++) begin
                ring[i] <= '0;
            end
        end else if (ce) begin
            ring[wp] <= in;
            wp       <= wp + 1'b1;
        end
    end

    // Combinational read of the slot written D ce cycles ago; the current
    // ce cycle's write lands after this read, so D=1 sees last cycle's input.
    assign rd_addr = wp - delay;
    assign out     = (delay == '0) ? in : ring[rd_addr];

endmodule

// File: rtl/sync_delay_ctrl.sv
// rtl/sync_delay_ctrl.sv - measures chain latency from marker edges and delays sideband by it
module sync_delay_ctrl
    import sync_delay_ctrl_pkg::*;
#(
    parameter int N         = 3,
    parameter int MAX_DELAY = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    sync_delay_ctrl_if.slave  bus
);

    localparam int AW   = calc_aw(MAX_DELAY);
    localparam int CW   = AW + 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(MAX_DELAY);

    localparam logic [2:0] IDLE    = ST_IDLE;
    localparam logic [2:0] ARM     = ST_ARM;
    localparam logic [2:0] MEASURE = ST_MEASURE;
    localparam logic [2:0] LOCKED  = ST_LOCKED;
    localparam logic [2:0] ERROR   = ST_ERROR;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [AW-1:0] delay_q;
    logic          locked_q;
    logic          error_q;
    logic          ref_in_q;
    logic          ref_out_q;
    logic          in_rise;
    logic          out_rise;

    assign in_rise  = bus.ref_in  & ~ref_in_q;
    assign out_rise = bus.ref_out & ~ref_out_q;
    assign cnt_inc  = cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            delay_q   <= '0;
            locked_q  <= 1'b0;
            error_q   <= 1'b0;
            ref_in_q  <= 1'b0;
            ref_out_q <= 1'b0;
        end else if (bus.ce) begin
            ref_in_q  <= bus.ref_in;
            ref_out_q <= bus.ref_out;
            case (state)
                IDLE, LOCKED, ERROR: begin
                    // The old delay keeps running until the next lock.
                    if (bus.start) begin
                        state    <= ARM;
                        locked_q <= 1'b0;
                        error_q  <= 1'b0;
                    end
                end
                ARM: begin
                    if (in_rise) begin
                        cnt <= '0;
                        if (out_rise) begin
                            delay_q  <= '0;
                            locked_q <= 1'b1;
                            state    <= LOCKED;
                        end else begin
                            state <= MEASURE;
                        end
                    end
                end
                MEASURE: begin
                    cnt <= cnt_inc;
                    if (out_rise) begin
                        delay_q  <= cnt_inc[AW-1:0];
                        locked_q <= 1'b1;
                        state    <= LOCKED;
                    end else if (cnt_inc == CNT_LIMIT) begin
                        error_q <= 1'b1;
                        state   <= ERROR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.delay  = delay_q;
    assign bus.busy   = (state == ARM) || (state == MEASURE);
    assign bus.locked = locked_q;
    assign bus.error  = error_q;

    var_delay_line #(
        .N         (N),
        .MAX_DELAY (MAX_DELAY)
    ) u_delay_line (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (bus.ce),
        .delay (delay_q),
        .in    (bus.in),
        .out   (bus.out)
    );

endmodule

// File: tb/tb_sync_delay_ctrl.sv
// tb/tb_sync_delay_ctrl.sv - directed bench with timestamp-based reference model for sync_delay_ctrl
module tb_sync_delay_ctrl;

    localparam int N    = 3;
    localparam int MAXD = 64;
    localparam int HLEN = 8192;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_delay_ctrl_if #(.N(N), .MAX_DELAY(MAXD)) bus ();

    sync_delay_ctrl #(.N(N), .MAX_DELAY(MAXD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit rand_in = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ce-cycle timestamps, input history and measurement flags.
    logic [N-1:0] hist [HLEN];
    int           n;
    int           t0;
    int           m_delay;
    bit           m_arm, m_meas, m_locked, m_err, p_in, p_out;
    logic         m_rin, m_rout;

    assign m_rin  = bus.ref_in  && !p_in;
    assign m_rout = bus.ref_out && !p_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n <= 0; t0 <= 0; m_delay <= 0;
            m_arm <= 0; m_meas <= 0; m_locked <= 0; m_err <= 0;
            p_in <= 0; p_out <= 0;
        end else if (bus.ce) begin
            if (!m_arm && !m_meas) begin
                if (bus.start) begin
                    m_arm <= 1; m_locked <= 0; m_err <= 0;
                end
            end else if (m_arm) begin
                if (m_rin) begin
                    m_arm <= 0;
                    if (m_rout) begin
                        m_delay <= 0; m_locked <= 1;
                    end else begin
                        m_meas <= 1; t0 <= n;
                    end
                end
            end else begin
                if (m_rout) begin
                    m_delay <= (n - t0) % MAXD; m_locked <= 1; m_meas <= 0;
                end else if (n - t0 == MAXD) begin
                    m_err <= 1; m_meas <= 0;
                end
            end
            if (n < HLEN) hist[n] <= bus.in;
            n     <= n + 1;
            p_in  <= bus.ref_in;
            p_out <= bus.ref_out;
        end
    end

    logic [N-1:0] e_out;
    always @(negedge clk) begin
        if (m_delay == 0)           e_out = bus.in;
        else if (n - m_delay >= 0)  e_out = hist[n - m_delay];
        else                        e_out = '0;
        chk("out",    bus.out,    e_out);
        chk("delay",  bus.delay,  m_delay);
        chk("busy",   bus.busy,   m_arm || m_meas);
        chk("locked", bus.locked, m_locked);
        chk("error",  bus.error,  m_err);
    end

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
            if (rand_in) bus.in = N'($urandom);
        end
    endtask

    task automatic measure(input int d);
        bus.start = 1; cyc(1);
        bus.start = 0; bus.ref_in = 0; bus.ref_out = 0; cyc(1);
        bus.ref_in = 1;
        if (d == 0) bus.ref_out = 1;
        cyc(1);
        if (d > 0) begin
            cyc(d - 1);
            bus.ref_out = 1;
            cyc(1);
        end
        bus.ref_in = 0; bus.ref_out = 0;
    endtask

    initial begin
        bus.ce = 1; bus.start = 0; bus.ref_in = 0; bus.ref_out = 0; bus.in = 3'b101;
        #2;
        chk("rst_out",    bus.out,    3'b101);
        chk("rst_delay",  bus.delay,  0);
        chk("rst_busy",   bus.busy,   0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_error",  bus.error,  0);
        @(posedge clk); #1;
        rst_n = 1;
        cyc(1);
        chk("idle_out", bus.out, 3'b101);
        rand_in = 1;

        // Latency of 7, then a marker value reappearing 7 cycles later.
        measure(7);
        chk("m7_delay",  bus.delay,  7);
        chk("m7_locked", bus.locked, 1);
        rand_in = 0;
        bus.in = 3'b110; cyc(1);
        bus.in = 3'b000; cyc(6);
        chk("m7_out", bus.out, 3'b110);
        rand_in = 1;

        // Coincident edges give zero delay and a live bypass.
        measure(0);
        chk("m0_delay",  bus.delay,  0);
        chk("m0_locked", bus.locked, 1);
        rand_in = 0;
        bus.in = 3'b011; #1;
        chk("m0_out_a", bus.out, 3'b011);
        bus.in = 3'b100; #1;
        chk("m0_out_b", bus.out, 3'b100);
        rand_in = 1;

        // Timeout keeps the prior delay.
        measure(7);
        bus.start = 1; cyc(1);
        bus.start = 0; cyc(1);
        bus.ref_in = 1; cyc(1);
        cyc(63);
        chk("to_pre_error", bus.error, 0);
        chk("to_pre_busy",  bus.busy,  1);
        cyc(1);
        chk("to_error",  bus.error,  1);
        chk("to_locked", bus.locked, 0);
        chk("to_delay",  bus.delay,  7);
        bus.ref_in = 0; cyc(2);

        // ce gaps, an ignored start and an ignored second ref_in edge.
        bus.start = 1; cyc(1);
        bus.start = 0; cyc(1);
        bus.ref_in = 1; cyc(1);
        for (int i = 1; i <= 4; i++) begin
            bus.ce = 0; bus.start = 1; cyc(1);
            bus.ce = 1; bus.start = (i == 1); bus.ref_in = (i != 2); cyc(1);
        end
        chk("gap_busy", bus.busy, 1);
        bus.ce = 0; bus.start = 0; bus.ref_out = 1; cyc(1);
        bus.ce = 1; cyc(1);
        chk("gap_delay",  bus.delay,  5);
        chk("gap_locked", bus.locked, 1);
        bus.ref_in = 0; bus.ref_out = 0; cyc(2);

        // Asynchronous reset in the middle of a measurement.
        bus.start = 1; cyc(1);
        bus.start = 0; cyc(1);
        bus.ref_in = 1; cyc(3);
        rand_in = 0;
        #2 rst_n = 0;
        bus.in = 3'b010;
        #1;
        chk("ar_out",    bus.out,    3'b010);
        chk("ar_delay",  bus.delay,  0);
        chk("ar_busy",   bus.busy,   0);
        chk("ar_locked", bus.locked, 0);
        chk("ar_error",  bus.error,  0);
        @(posedge clk); #1;
        rst_n = 1; bus.ref_in = 0;
        rand_in = 1;
        cyc(1);
        measure(12);
        chk("m12_delay",  bus.delay,  12);
        chk("m12_locked", bus.locked, 1);
        rand_in = 0;
        bus.in = 3'b111; cyc(1);
        bus.in = 3'b000; cyc(11);
        chk("m12_out", bus.out, 3'b111);
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
